// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction-fetch prefetch unit.
// Optional feature macro: IFU_ACCESS_FAULT_EN adds a per-entry access-fault bit.
package ifu_pkg;

    localparam int ILEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Default FIFO entry for a 32-bit PC; the top builds its own XLEN-sized copy.
    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] inst;
`ifdef IFU_ACCESS_FAULT_EN
        logic            fault;
`endif
    } fifo_entry_t;

    // Width of a counter that must hold every value from 0 up to depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: redirect, instruction-memory and decode-side handshakes of the
// prefetch unit. The master modport is the fetch unit, the slave modport is the
// surrounding core/memory. IFU_ACCESS_FAULT_EN adds imem_rsp_err and out_fault.
interface ifu_prefetch_if #(
    parameter int XLEN = 32
);
    import ifu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;

`ifdef IFU_ACCESS_FAULT_EN
    logic            imem_rsp_err;
    logic            out_fault;
`endif

    modport master (
`ifdef IFU_ACCESS_FAULT_EN
        input  imem_rsp_err,
        output out_fault,
`endif
        input  redirect_valid,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst
    );

    modport slave (
`ifdef IFU_ACCESS_FAULT_EN
        output imem_rsp_err,
        input  out_fault,
`endif
        output redirect_valid,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst
    );

endinterface

// File: rtl/ifu_fifo.sv
// ifu_fifo: small synchronous FIFO holding fetched entries for decode.
// Flush wins over push and over the pop, so a redirect empties it in one cycle
// while a same-cycle pop is simply absorbed by the flush.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fifo_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = credit_width(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_pop;
    logic            do_push;

    // A pop on an empty FIFO is ignored; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL) || do_pop);
    end

    // Storage, pointers and occupancy; storage is cleared so an idle head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with a DEPTH-entry prefetch buffer.
// Requests are issued only while buffered plus in-flight fetches leave a free slot,
// so every response always has room. A redirect flushes the buffer, restarts fetch
// at the (word-aligned) target and discards responses still owed to old requests.
// Optional feature macro: IFU_ACCESS_FAULT_EN stores and reports access faults.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ifu_prefetch_if.master bus
);
    localparam int              CW      = credit_width(DEPTH);
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
`ifdef IFU_ACCESS_FAULT_EN
        logic            fault;
`endif
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_next;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] rsp_pc_next;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     used;
    logic            req_fire;
    logic            rsp_fire;
    logic            pop_fire;
    logic            push;
    entry_t          push_data;
    entry_t          head;

    // Handshake decode and credit check; everything here depends only on registered state or inputs.
    always_comb begin
        used                = {1'b0, fifo_count} + {1'b0, inflight};
        bus.imem_req_valid  = used < CREDITS;
        bus.imem_req_addr   = fetch_pc;
        bus.out_valid       = fifo_count != '0;
        req_fire            = bus.imem_req_valid && bus.imem_req_ready;
        rsp_fire            = bus.imem_rsp_valid;
        pop_fire            = bus.out_valid && bus.out_ready;
        redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    // Next-state for fetch/response PCs and the in-flight and stale-response counters; redirect overrides.
    always_comb begin
        fetch_pc_next = fetch_pc;
        rsp_pc_next   = rsp_pc;
        drop_next     = drop;
        push          = 1'b0;
        inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);
        if (req_fire) begin
            fetch_pc_next = fetch_pc + STEP;
        end
        if (rsp_fire) begin
            if (drop != '0) begin
                drop_next = drop - 1'b1;
            end else begin
                push        = 1'b1;
                rsp_pc_next = rsp_pc + STEP;
            end
        end
        if (bus.redirect_valid) begin
            fetch_pc_next = redirect_target;
            rsp_pc_next   = redirect_target;
            drop_next     = inflight_next;
            push          = 1'b0;
        end
    end

    // Assemble the entry written for an accepted response.
    always_comb begin
        push_data      = '0;
        push_data.pc   = rsp_pc;
        push_data.inst = bus.imem_rsp_data;
`ifdef IFU_ACCESS_FAULT_EN
        push_data.fault = bus.imem_rsp_err;
`endif
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            fetch_pc <= fetch_pc_next;
            rsp_pc   <= rsp_pc_next;
            inflight <= inflight_next;
            drop     <= drop_next;
        end
    end

    ifu_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_fire),
        .flush     (bus.redirect_valid),
        .head_data (head),
        .count     (fifo_count)
    );

    assign bus.out_pc   = head.pc;
    assign bus.out_inst = head.inst;
`ifdef IFU_ACCESS_FAULT_EN
    assign bus.out_fault = head.fault;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch. Instance A (DEPTH 2) sees a
// zero-latency memory answering in the request cycle; instance B (DEPTH 4) sees a
// fixed three-cycle memory. Instruction words are the bitwise inverse of the address.
module tb_ifu_prefetch;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   a_req_count;

    always #5 clk = ~clk;

    ifu_prefetch_if #(.XLEN(32)) ifA ();
    ifu_prefetch_if #(.XLEN(32)) ifB ();

    ifu_prefetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(2)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    ifu_prefetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .DEPTH(4)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    // Memory A: always ready, responds combinationally in the handshake cycle.
    assign ifA.imem_req_ready = 1'b1;
    assign ifA.imem_rsp_valid = ifA.imem_req_valid && ifA.imem_req_ready;
    assign ifA.imem_rsp_data  = ~ifA.imem_req_addr;

    // Memory B: always ready, responds exactly three cycles after the handshake.
    logic [2:0]  b_v;
    logic [31:0] b_a [3];
    assign ifB.imem_req_ready = 1'b1;
    assign ifB.imem_rsp_valid = b_v[2];
    assign ifB.imem_rsp_data  = ~b_a[2];

`ifdef IFU_ACCESS_FAULT_EN
    assign ifA.imem_rsp_err = (ifA.imem_req_addr == 32'h8000_0004);
    assign ifB.imem_rsp_err = 1'b0;
`endif

    // Three-stage delay line modelling memory B's latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_v <= '0;
            for (int i = 0; i < 3; i++) b_a[i] <= '0;
        end else begin
            b_v    <= {b_v[1:0], ifB.imem_req_valid && ifB.imem_req_ready};
            b_a[0] <= ifB.imem_req_addr;
            b_a[1] <= b_a[0];
            b_a[2] <= b_a[1];
        end
    end

    // Count request handshakes seen by memory A since the last reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_req_count <= 0;
        else if (ifA.imem_req_valid && ifA.imem_req_ready) a_req_count <= a_req_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifA.redirect_valid = 1'b0;
        ifA.redirect_pc    = '0;
        ifA.out_ready      = 1'b1;
        ifB.redirect_valid = 1'b0;
        ifB.redirect_pc    = '0;
        ifB.out_ready      = 1'b1;

        // Reset values
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_addr", ifA.imem_req_addr, 32'h8000_0000);
        checkOutput("rst_out_valid", 32'(ifA.out_valid), 32'd0);
        checkOutput("rst_out_pc", ifA.out_pc, 32'h0);
        checkOutput("rst_out_inst", ifA.out_inst, 32'h0);
`ifdef IFU_ACCESS_FAULT_EN
        checkOutput("rst_out_fault", 32'(ifA.out_fault), 32'd0);
`endif

        // Streaming after reset release, zero-latency memory
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("c1_req_valid", 32'(ifA.imem_req_valid), 32'd1);
        checkOutput("c1_req_addr", ifA.imem_req_addr, 32'h8000_0000);
        checkOutput("c1_out_valid", 32'(ifA.out_valid), 32'd0);
        applyStimulus();
        checkOutput("c2_out_valid", 32'(ifA.out_valid), 32'd1);
        checkOutput("c2_out_pc", ifA.out_pc, 32'h8000_0000);
        checkOutput("c2_out_inst", ifA.out_inst, 32'h7FFF_FFFF);
`ifdef IFU_ACCESS_FAULT_EN
        checkOutput("c2_out_fault", 32'(ifA.out_fault), 32'd0);
`endif
        applyStimulus();
        checkOutput("c3_out_valid", 32'(ifA.out_valid), 32'd1);
        checkOutput("c3_out_pc", ifA.out_pc, 32'h8000_0004);
        checkOutput("c3_out_inst", ifA.out_inst, 32'h7FFF_FFFB);
`ifdef IFU_ACCESS_FAULT_EN
        checkOutput("c3_out_fault", 32'(ifA.out_fault), 32'd1);
`endif
        applyStimulus();
        checkOutput("c4_out_valid", 32'(ifA.out_valid), 32'd1);
        checkOutput("c4_out_pc", ifA.out_pc, 32'h8000_0008);
`ifdef IFU_ACCESS_FAULT_EN
        checkOutput("c4_out_fault", 32'(ifA.out_fault), 32'd0);
`endif

        // Mid-operation reset, then decode stalled: buffer fills and requests stop
        ifA.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(ifA.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 2; k <= 10; k++) begin
            applyStimulus();
            checkOutput($sformatf("stall_c%0d_out_pc", k), ifA.out_pc, 32'h8000_0000);
        end
        checkOutput("stall_req_count", 32'(a_req_count), 32'd2);
        checkOutput("stall_req_valid", 32'(ifA.imem_req_valid), 32'd0);
        checkOutput("stall_out_valid", 32'(ifA.out_valid), 32'd1);
        checkOutput("stall_out_inst", ifA.out_inst, 32'h7FFF_FFFF);

        // Release decode: full-buffer pop, then refill
        ifA.out_ready = 1'b1;
        applyStimulus();
        checkOutput("drain_out_pc0", ifA.out_pc, 32'h8000_0004);
        applyStimulus();
        checkOutput("drain_out_pc1", ifA.out_pc, 32'h8000_0008);

        // Redirect together with an out handshake and a response
        ifA.redirect_valid = 1'b1;
        ifA.redirect_pc    = 32'h8000_0203;
        applyStimulus();
        ifA.redirect_valid = 1'b0;
        checkOutput("redir_req_addr", ifA.imem_req_addr, 32'h8000_0200);
        checkOutput("redir_out_valid", 32'(ifA.out_valid), 32'd0);
        applyStimulus();
        checkOutput("redir_out_valid2", 32'(ifA.out_valid), 32'd1);
        checkOutput("redir_out_pc", ifA.out_pc, 32'h8000_0200);
        checkOutput("redir_out_inst", ifA.out_inst, 32'h7FFF_FDFF);

        // Fetch address wraps past the top of the address space
        ifA.redirect_valid = 1'b1;
        ifA.redirect_pc    = 32'hFFFF_FFFC;
        applyStimulus();
        ifA.redirect_valid = 1'b0;
        checkOutput("wrap_req_addr0", ifA.imem_req_addr, 32'hFFFF_FFFC);
        checkOutput("wrap_out_valid", 32'(ifA.out_valid), 32'd0);
        applyStimulus();
        checkOutput("wrap_req_addr1", ifA.imem_req_addr, 32'h0000_0000);
        checkOutput("wrap_out_pc0", ifA.out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_out_inst0", ifA.out_inst, 32'h0000_0003);
        applyStimulus();
        checkOutput("wrap_out_pc1", ifA.out_pc, 32'h0000_0000);
        checkOutput("wrap_out_inst1", ifA.out_inst, 32'hFFFF_FFFF);

        // DEPTH 4, three-cycle memory: redirect with three requests outstanding
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("b_c1_req_valid", 32'(ifB.imem_req_valid), 32'd1);
        checkOutput("b_c1_req_addr", ifB.imem_req_addr, 32'h8000_0000);
        applyStimulus();
        checkOutput("b_c2_req_addr", ifB.imem_req_addr, 32'h8000_0004);
        applyStimulus();
        checkOutput("b_c3_req_addr", ifB.imem_req_addr, 32'h8000_0008);
        ifB.redirect_valid = 1'b1;
        ifB.redirect_pc    = 32'h8000_1002;
        applyStimulus();
        ifB.redirect_valid = 1'b0;
        checkOutput("b_c4_req_addr", ifB.imem_req_addr, 32'h8000_1000);
        checkOutput("b_c4_req_valid", 32'(ifB.imem_req_valid), 32'd1);
        checkOutput("b_c4_out_valid", 32'(ifB.out_valid), 32'd0);
        for (int k = 5; k <= 7; k++) begin
            applyStimulus();
            checkOutput($sformatf("b_c%0d_out_valid", k), 32'(ifB.out_valid), 32'd0);
        end
        applyStimulus();
        checkOutput("b_c8_out_valid", 32'(ifB.out_valid), 32'd1);
        checkOutput("b_c8_out_pc", ifB.out_pc, 32'h8000_1000);
        checkOutput("b_c8_out_inst", ifB.out_inst, 32'h7FFF_EFFF);
        checkOutput("b_c8_req_valid", 32'(ifB.imem_req_valid), 32'd0);
        applyStimulus();
        checkOutput("b_c9_out_pc", ifB.out_pc, 32'h8000_1004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
